// File: rtl/ram_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_req_ctrl_pkg
// Description : Shared types and helpers for the RAM request front-end:
//               FSM state encoding, the registered request record and the
//               byte-merge used by read-modify-write.
//               Record fields are sized for the largest supported
//               configuration; the controller zero-extends into them and
//               slices back out, so one typedef serves every parameter set.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_req_ctrl_pkg;

  localparam int c_MAX_ADDR_WIDTH = 64;
  localparam int c_MAX_WORD_WIDTH = 256;
  localparam int c_MAX_NB         = c_MAX_WORD_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [c_MAX_ADDR_WIDTH-1:0] addr;
    logic                        we;
    logic [c_MAX_NB-1:0]         be;
    logic [c_MAX_WORD_WIDTH-1:0] wdata;
  } req_t;

  // Byte lanes with be set take new_w, the rest keep old_w.
  function automatic logic [c_MAX_WORD_WIDTH-1:0] merge(
    input logic [c_MAX_WORD_WIDTH-1:0] old_w,
    input logic [c_MAX_WORD_WIDTH-1:0] new_w,
    input logic [c_MAX_NB-1:0]         be
  );
    logic [c_MAX_WORD_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < c_MAX_NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_req_ctrl
// Description : Request front-end for a single-port block RAM without byte
//               enables. Turns a valid/ready byte-addressed request with byte
//               strobes into RAM en/we/addr/din; partial writes become a
//               read-modify-write. One registered response per request.
// Config macro: RAM_CTRL_ADDR_CHECK_EN - out-of-window addresses get an error
//               response and no RAM access; otherwise addresses alias.
// Ports       : clk, rst_i (sync, active high)
//               req_valid_i/req_ready_o, req_addr_i, req_we_i, req_be_i,
//               req_wdata_i                  - request channel
//               rsp_valid_o, rsp_rdata_o, rsp_err_o - response (no backpressure)
//               ram_addr_o, ram_en_o, ram_we_o, ram_din_o, ram_dout_i - RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module ram_req_ctrl
  import ram_req_ctrl_pkg::*;
#(
  parameter int                    DEPTH      = 1024,
  parameter int                    WORD_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic                     req_we_i,
  input  logic [WORD_WIDTH/8-1:0]  req_be_i,
  input  logic [WORD_WIDTH-1:0]    req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [WORD_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH)-1:0] ram_addr_o,
  output logic                     ram_en_o,
  output logic                     ram_we_o,
  output logic [WORD_WIDTH-1:0]    ram_din_o,
  input  logic [WORD_WIDTH-1:0]    ram_dout_i
);

  localparam int c_NB   = WORD_WIDTH / 8;
  localparam int c_OFFS = $clog2(c_NB);
  localparam int c_AW   = $clog2(DEPTH);

  state_t                  r_state;
  state_t                  w_state_nxt;
  req_t                    r_req;
  req_t                    w_req_in;
  logic                    r_rsp_valid;
  logic [WORD_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_addr_err;
  logic [ADDR_WIDTH-1:0]   w_rel;
  logic [ADDR_WIDTH-1:0]   w_reg_rel;
  logic [c_AW-1:0]         w_word_idx;
  logic [c_AW-1:0]         w_reg_word;
  logic [c_MAX_WORD_WIDTH-1:0] w_merge_full;

  logic                    w_ram_en;
  logic                    w_ram_we;
  logic [c_AW-1:0]         w_ram_addr;
  logic [WORD_WIDTH-1:0]   w_ram_din;
  logic                    w_rsp_set;
  logic [WORD_WIDTH-1:0]   w_rsp_rdata_nxt;
  logic                    w_rsp_err_nxt;
  logic                    w_unused_bits;

  // Offset from the window base; a request below BASE_ADDR wraps to a large
  // value and therefore falls outside the window as well.
  assign w_rel      = req_addr_i - BASE_ADDR;
  assign w_word_idx = w_rel[c_OFFS +: c_AW];
  assign w_reg_rel  = r_req.addr[ADDR_WIDTH-1:0] - BASE_ADDR;
  assign w_reg_word = w_reg_rel[c_OFFS +: c_AW];

`ifdef RAM_CTRL_ADDR_CHECK_EN
  // In window iff every offset bit above the word index is zero.
  assign w_addr_err = |(w_rel >> (c_OFFS + c_AW));
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_ready  = (r_state == IDLE) && !rst_i;
  assign w_accept = req_valid_i && w_ready;

  assign w_merge_full = merge(c_MAX_WORD_WIDTH'(ram_dout_i), r_req.wdata, r_req.be);

  always_comb begin
    w_req_in       = '0;
    w_req_in.addr  = c_MAX_ADDR_WIDTH'(req_addr_i);
    w_req_in.we    = req_we_i;
    w_req_in.be    = c_MAX_NB'(req_be_i);
    w_req_in.wdata = c_MAX_WORD_WIDTH'(req_wdata_i);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ram_en        = 1'b0;
    w_ram_we        = 1'b0;
    w_ram_addr      = w_reg_word;
    w_ram_din       = r_req.wdata[WORD_WIDTH-1:0];
    w_rsp_set       = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        // The RAM is driven straight from the request so the access lands
        // in the acceptance cycle.
        w_ram_addr = w_word_idx;
        w_ram_din  = req_wdata_i;
        if (w_accept) begin
          if (w_addr_err) begin
            w_rsp_set     = 1'b1;
            w_rsp_err_nxt = 1'b1;
          end else if (!req_we_i) begin
            w_ram_en    = 1'b1;
            w_state_nxt = RD_WAIT;
          end else if (&req_be_i) begin
            w_ram_en  = 1'b1;
            w_ram_we  = 1'b1;
            w_rsp_set = 1'b1;
          end else if (!(|req_be_i)) begin
            w_rsp_set = 1'b1;
          end else begin
            // Partial write: fetch the old word first.
            w_ram_en    = 1'b1;
            w_state_nxt = RMW_WR;
          end
        end
      end
      RD_WAIT: begin
        w_rsp_set       = 1'b1;
        w_rsp_rdata_nxt = ram_dout_i;
        w_state_nxt     = IDLE;
      end
      RMW_WR: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_din   = w_merge_full[WORD_WIDTH-1:0];
        w_rsp_set   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_accept) r_req <= w_req_in;
      r_rsp_valid <= w_rsp_set;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Reset gates the RAM strobes so an in-flight RMW write is dropped.
  assign req_ready_o = w_ready;
  assign ram_en_o    = w_ram_en && !rst_i;
  assign ram_we_o    = w_ram_we && !rst_i;
  assign ram_addr_o  = w_ram_addr;
  assign ram_din_o   = w_ram_din;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

  // Record bits beyond this configuration's widths are constant zero.
  assign w_unused_bits = ^{r_req, w_rel, w_reg_rel, w_merge_full};

endmodule
`default_nettype wire

// File: tb/tb_ram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_req_ctrl
// Description : Self-checking bench for ram_req_ctrl with a behavioural
//               single-port RAM. A vector table plus hand-written sequences
//               push expected responses to a queue that a response monitor
//               pops and compares. Honours RAM_CTRL_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [9:0]  ram_addr_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [31:0] ram_din_o;
  logic [31:0] ram_dout_i;

  ram_req_ctrl #(
    .DEPTH      (1024),
    .WORD_WIDTH (32),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .ram_addr_o  (ram_addr_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_din_o   (ram_din_o),
    .ram_dout_i  (ram_dout_i)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous read, one cycle latency.
  logic [31:0] mem [0:1023] = '{default: '0};
  int          ram_wr_cnt = 0;
  int          ram_acc_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en_o) begin
      ram_acc_cnt <= ram_acc_cnt + 1;
      if (ram_we_o) begin
        mem[ram_addr_o] <= ram_din_o;
        ram_wr_cnt      <= ram_wr_cnt + 1;
      end else begin
        ram_dout_i <= mem[ram_addr_o];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        en;
    logic        ram_we;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && rsp_valid_o) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected 0 (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("rsp_rdata", rsp_rdata_o, e.rdata);
          check("rsp_err", 32'(rsp_err_o), 32'(e.err));
          check("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  endtask

  // Drives one request from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, input logic push,
                      input logic [31:0] er, input logic ee, input int lat,
                      input logic een, input logic ewe, output int waited);
    exp_t e;
    logic acc;
    acc         = 1'b0;
    waited      = 0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_we_i    = w;
    req_be_i    = b;
    req_wdata_i = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        acc = 1'b1;
        check("ram_en_at_accept", 32'(ram_en_o), 32'(een));
        check("ram_we_at_accept", 32'(ram_we_o), 32'(ewe));
        if (push) begin
          e.rdata = er;
          e.err   = ee;
          e.due   = cyc + lat;
          sbq.push_back(e);
        end
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int snap;

    // addr, we, be, wdata, exp rdata, exp err, latency, en@N, we@N
    vt[0]  = '{32'h10, 1'b1, 4'hF, 32'h11223344, 32'h0,        1'b0, 1, 1'b1, 1'b1};
    vt[1]  = '{32'h10, 1'b0, 4'h0, 32'h0,        32'h11223344, 1'b0, 2, 1'b1, 1'b0};
    vt[2]  = '{32'h10, 1'b1, 4'h2, 32'hAABBCCDD, 32'h0,        1'b0, 2, 1'b1, 1'b0};
    vt[3]  = '{32'h10, 1'b0, 4'h0, 32'h0,        32'h1122CC44, 1'b0, 2, 1'b1, 1'b0};
    vt[4]  = '{32'h20, 1'b1, 4'h0, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1'b0, 1'b0};
    vt[5]  = '{32'h20, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 2, 1'b1, 1'b0};
`ifdef RAM_CTRL_ADDR_CHECK_EN
    vt[6]  = '{32'h1000, 1'b1, 4'hF, 32'h55667788, 32'h0,      1'b1, 1, 1'b0, 1'b0};
    vt[7]  = '{32'h0,    1'b0, 4'h0, 32'h0,        32'h0,      1'b0, 2, 1'b1, 1'b0};
    vt[8]  = '{32'h1000, 1'b0, 4'h0, 32'h0,        32'h0,      1'b1, 1, 1'b0, 1'b0};
`else
    vt[6]  = '{32'h1000, 1'b1, 4'hF, 32'h55667788, 32'h0,        1'b0, 1, 1'b1, 1'b1};
    vt[7]  = '{32'h0,    1'b0, 4'h0, 32'h0,        32'h55667788, 1'b0, 2, 1'b1, 1'b0};
    vt[8]  = '{32'h1000, 1'b0, 4'h0, 32'h0,        32'h55667788, 1'b0, 2, 1'b1, 1'b0};
`endif
    vt[9]  = '{32'h14, 1'b1, 4'h9, 32'hA1B2C3D4, 32'h0,        1'b0, 2, 1'b1, 1'b0};
    vt[10] = '{32'h14, 1'b0, 4'h0, 32'h0,        32'hA10000D4, 1'b0, 2, 1'b1, 1'b0};
    vt[11] = '{32'h10, 1'b1, 4'hC, 32'h99887766, 32'h0,        1'b0, 2, 1'b1, 1'b0};
    vt[12] = '{32'h13, 1'b0, 4'h0, 32'h0,        32'h9988CC44, 1'b0, 2, 1'b1, 1'b0};
    vt[13] = '{32'h11, 1'b0, 4'h0, 32'h0,        32'h9988CC44, 1'b0, 2, 1'b1, 1'b0};

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_we_i    = 1'b0;
    req_be_i    = '0;
    req_wdata_i = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("reset_rsp_rdata", rsp_rdata_o, 32'h0);
    check("reset_rsp_err", 32'(rsp_err_o), 32'h0);
    check("reset_ram_en", 32'(ram_en_o), 32'h0);
    check("reset_ram_we", 32'(ram_we_o), 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready_o), 32'h1);
    check("idle_ram_en", 32'(ram_en_o), 32'h0);
    @(posedge clk);
    #1;

    // Table of single requests
    for (int i = 0; i < 14; i++) begin
      send(vt[i].addr, vt[i].we, vt[i].be, vt[i].wdata, 1'b1,
           vt[i].rdata, vt[i].err, vt[i].lat, vt[i].en, vt[i].ram_we, w);
    end
    drain();

    // RMW: read then merged write on the following cycle
    send(32'h18, 1'b1, 4'h1, 32'h123456EE, 1'b1, 32'h0, 1'b0, 2, 1'b1, 1'b0, w);
    @(negedge clk);
    check("rmw_wr_en", 32'(ram_en_o), 32'h1);
    check("rmw_wr_we", 32'(ram_we_o), 32'h1);
    check("rmw_wr_addr", 32'(ram_addr_o), 32'h6);
    check("rmw_wr_din", ram_din_o, 32'h000000EE);
    drain();

    // be==0 write: no RAM access at all, word unchanged
    snap = ram_acc_cnt;
    send(32'h24, 1'b1, 4'h0, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 1, 1'b0, 1'b0, w);
    drain();
    check("be0_ram_accesses", 32'(ram_acc_cnt - snap), 32'h0);
    send(32'h24, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, 2, 1'b1, 1'b0, w);
    drain();

    // Back-to-back full writes: ready never drops
    send(32'h0, 1'b1, 4'hF, 32'h01010101, 1'b1, 32'h0, 1'b0, 1, 1'b1, 1'b1, w);
    send(32'h4, 1'b1, 4'hF, 32'h02020202, 1'b1, 32'h0, 1'b0, 1, 1'b1, 1'b1, w);
    check("b2b_wait_1", 32'(w), 32'h0);
    send(32'h8, 1'b1, 4'hF, 32'h03030303, 1'b1, 32'h0, 1'b0, 1, 1'b1, 1'b1, w);
    check("b2b_wait_2", 32'(w), 32'h0);
    send(32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h01010101, 1'b0, 2, 1'b1, 1'b0, w);
    check("read_after_b2b_wait", 32'(w), 32'h0);
    send(32'h4, 1'b0, 4'h0, 32'h0, 1'b1, 32'h02020202, 1'b0, 2, 1'b1, 1'b0, w);
    check("read_throughput_wait", 32'(w), 32'h1);
    send(32'h8, 1'b0, 4'h0, 32'h0, 1'b1, 32'h03030303, 1'b0, 2, 1'b1, 1'b0, w);
    drain();

    // Reset during RMW_WR: write dropped, no response
    send(32'h10, 1'b1, 4'h1, 32'h000000FF, 1'b0, 32'h0, 1'b0, 2, 1'b1, 1'b0, w);
    rst_i = 1'b1;
    snap  = ram_wr_cnt;
    @(negedge clk);
    check("rst_rmw_ram_we", 32'(ram_we_o), 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_rmw_ready", 32'(req_ready_o), 32'h1);
    check("rst_rmw_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_rmw_ram_en", 32'(ram_en_o), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rmw_writes", 32'(ram_wr_cnt - snap), 32'h0);
    send(32'h10, 1'b0, 4'h0, 32'h0, 1'b1, 32'h9988CC44, 1'b0, 2, 1'b1, 1'b0, w);
    drain();

    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
